// File: rtl/prefetch_fetch_if.sv
// Fetch unit bundle: redirect input, instruction-memory request/response, decode-side output.
interface prefetch_fetch_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned INST_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_resp_valid;
    logic [INST_W-1:0] imem_resp_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid, imem_resp_data,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid, imem_resp_data,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );
endinterface

// File: rtl/prefetch_fetch_unit.sv
// Sequential instruction prefetcher: credit-limited requests, in-order response tagging,
// prefetch FIFO towards decode, and redirect flush with in-flight response dropping.
module prefetch_fetch_unit #(
    parameter int unsigned       ADDR_W    = 64,
    parameter int unsigned       INST_W    = 32,
    parameter int unsigned       BUF_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input logic              clk,
    input logic              reset,
    prefetch_fetch_if.master bus
);
    localparam int unsigned STEP  = INST_W / 8;
    localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] fifo_inst [BUF_DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [BUF_DEPTH];
    logic [ADDR_W-1:0] tag_q     [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, tag_rd, tag_wr;
    logic [CNT_W-1:0]  count, inflight, drop_cnt;

    logic              credit_ok, req_valid_c, req_fire, resp, push, pop;
    logic [ADDR_W-1:0] aligned_pc;

    // Credit covers both FIFO occupancy and every outstanding request, dropped ones included.
    always_comb begin
        credit_ok   = ((CNT_W+1)'(inflight) + (CNT_W+1)'(count)) < (CNT_W+1)'(BUF_DEPTH);
        req_valid_c = !reset && !bus.redirect_valid && credit_ok;
        req_fire    = req_valid_c && bus.imem_req_ready;
        resp        = bus.imem_resp_valid;
        push        = resp && !bus.redirect_valid && (drop_cnt == '0);
        pop         = (count != '0) && bus.out_ready;
        aligned_pc  = bus.redirect_pc & ~ADDR_W'(STEP - 1);
    end

    assign bus.imem_req_valid = req_valid_c;
    assign bus.imem_req_addr  = pc;
    assign bus.out_valid      = (count != '0);
    assign bus.out_inst       = fifo_inst[rd_ptr];
    assign bus.out_pc         = fifo_pc[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            tag_rd   <= '0;
            tag_wr   <= '0;
            count    <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + CNT_W'(req_fire) - CNT_W'(resp);
            // Tag queue tracks every response, so it stays aligned across redirects.
            if (resp)     tag_rd <= tag_rd + PTR_W'(1);
            if (req_fire) tag_wr <= tag_wr + PTR_W'(1);
            if (bus.redirect_valid) begin
                pc       <= aligned_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop_cnt <= inflight - CNT_W'(resp);
            end else begin
                if (req_fire)                  pc       <= pc + ADDR_W'(STEP);
                if (resp && drop_cnt != '0)    drop_cnt <= drop_cnt - CNT_W'(1);
                if (push)                      wr_ptr   <= wr_ptr + PTR_W'(1);
                if (pop)                       rd_ptr   <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Storage arrays carry no reset; validity comes from the pointers and counters.
    always_ff @(posedge clk) begin
        if (req_fire) tag_q[tag_wr] <= pc;
        if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_resp_data;
            fifo_pc[wr_ptr]   <= tag_q[tag_rd];
        end
    end
endmodule

// File: tb/tb_prefetch_fetch_unit.sv
// Randomized scoreboard bench for prefetch_fetch_unit with an in-order memory model.
module tb_prefetch_fetch_unit;
    localparam int unsigned ADDR_W    = 64;
    localparam int unsigned INST_W    = 32;
    localparam int unsigned BUF_DEPTH = 4;
    localparam logic [63:0] RESET_PC  = 64'hFFFF_FFFF_FFFF_FFF8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    prefetch_fetch_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

    prefetch_fetch_unit #(
        .ADDR_W(ADDR_W), .INST_W(INST_W), .BUF_DEPTH(BUF_DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_inst(input logic [63:0] a);
        return a[31:0] ^ {a[39:32], a[63:40]} ^ 32'h9E37_79B9;
    endfunction

    function automatic logic [63:0] align4(input logic [63:0] a);
        return a & ~64'h3;
    endfunction

    // ---------------- memory model: in-order, random latency >= 1 ----------------
    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;
    pend_t       pend[$];
    int          cyc = 0;
    int unsigned lat_min = 1;
    int unsigned lat_max = 1;

    always begin : mem_model
        logic        fire, took, rs;
        logic [63:0] a;
        @(negedge clk);
        fire = bus.imem_req_valid && bus.imem_req_ready;
        a    = bus.imem_req_addr;
        took = bus.imem_resp_valid;
        rs   = reset;
        @(posedge clk);
        cyc++;
        #1;
        if (rs || reset) pend.delete();
        else begin
            if (took && pend.size() > 0) void'(pend.pop_front());
            if (fire) pend.push_back('{addr: a, due: cyc + int'($urandom_range(lat_max, lat_min)) - 1});
        end
        if (!reset && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = ref_inst(pend[0].addr);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = '0;
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [63:0] exp_q[$];
    logic [63:0] req_pc = RESET_PC;
    logic [63:0] stall_addr = '0;
    logic [63:0] e;
    logic        stall_prev = 1'b0;
    int          n_req = 0;
    int          n_out = 0;

    always @(negedge clk) begin
        if (reset) begin
            check1("reset_out_valid", bus.out_valid, 1'b0);
            check1("reset_req_valid", bus.imem_req_valid, 1'b0);
            exp_q.delete();
            req_pc     = RESET_PC;
            stall_prev = 1'b0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got pc 0x%0h expected none outstanding", bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", bus.out_pc, e);
                    check("out_inst", 64'(bus.out_inst), 64'(ref_inst(e)));
                end
                n_out++;
            end
            if (stall_prev && !bus.redirect_valid) begin
                check1("stall_hold_valid", bus.imem_req_valid, 1'b1);
                check("stall_hold_addr", bus.imem_req_addr, stall_addr);
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", bus.imem_req_addr, req_pc);
                exp_q.push_back(req_pc);
                req_pc = req_pc + 64'd4;
                n_req++;
            end
            if (bus.redirect_valid) begin
                check1("redir_no_req", bus.imem_req_valid, 1'b0);
                exp_q.delete();
                req_pc = align4(bus.redirect_pc);
            end
            stall_prev = bus.imem_req_valid && !bus.imem_req_ready;
            stall_addr = bus.imem_req_addr;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [63:0] target);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        int base;
        int k;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;

        // Reset release, one-cycle memory: first out_valid two cycles later, wrap past 2^64.
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("lat_c0_out_valid", bus.out_valid, 1'b0);
        check1("first_req_valid", bus.imem_req_valid, 1'b1);
        check("first_req_addr", bus.imem_req_addr, RESET_PC);
        @(negedge clk);
        check1("lat_c1_out_valid", bus.out_valid, 1'b0);
        @(negedge clk);
        check1("lat_c2_out_valid", bus.out_valid, 1'b1);
        check("lat_c2_out_pc", bus.out_pc, RESET_PC);
        repeat (8) begin
            @(negedge clk);
            check1("stream_valid", bus.out_valid, 1'b1);
        end

        // Decode stall after redirect to 0: exactly BUF_DEPTH requests, then credit blocks.
        step();
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0;
        step();
        bus.redirect_valid = 1'b0;
        base = n_req;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("stall_req_count", 64'(n_req - base), 64'(BUF_DEPTH));
        check1("stall_req_blocked", bus.imem_req_valid, 1'b0);
        check1("stall_out_valid", bus.out_valid, 1'b1);
        check("stall_head_pc", bus.out_pc, 64'h0);
        step();
        bus.out_ready = 1'b1;
        repeat (8) step();

        // Redirect with responses in flight (latency 3).
        lat_min = 3;
        lat_max = 3;
        repeat (8) step();
        redirect_to(64'h100);
        @(negedge clk);
        check1("redir_clears_out", bus.out_valid, 1'b0);
        repeat (12) step();

        // Redirect coinciding with a response, unaligned target.
        lat_min = 1;
        lat_max = 1;
        repeat (6) step();
        redirect_to(64'h203);
        @(negedge clk);
        check1("redir2_clears_out", bus.out_valid, 1'b0);
        k = 0;
        while (!bus.out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("redir_align_head", bus.out_pc, 64'h200);
        repeat (6) step();

        // Asynchronous reset mid-run drops out_valid immediately.
        bus.out_ready = 1'b0;
        repeat (6) step();
        @(negedge clk);
        check1("pre_reset_out_valid", bus.out_valid, 1'b1);
        step();
        reset = 1'b1;
        #1;
        check1("async_out_valid", bus.out_valid, 1'b0);
        check1("async_req_valid", bus.imem_req_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) step();

        // Random traffic: memory stalls, decode stalls, redirects, variable latency.
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            step();
            bus.imem_req_ready = ($urandom_range(9, 0) < 7);
            bus.out_ready      = ($urandom_range(9, 0) < 7);
            bus.redirect_valid = ($urandom_range(99, 0) < 3);
            if ($urandom_range(3, 0) == 0)
                bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
            else
                bus.redirect_pc = {$urandom, $urandom};
        end

        // Drain: the unit must keep delivering with everything open.
        step();
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.out_ready      = 1'b1;
        lat_max            = 2;
        base = n_out;
        k = 0;
        while ((n_out - base) < 30 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check1("drain_progress", (n_out - base) >= 30, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
